mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's 4-bit loadable up counter.
- Adds configurable width and modulus, up/down direction, count enable, and wrap or saturate mode.
- Adds boundary flags, a one-cycle boundary-event pulse and a sticky overflow flag with clear.
- Used as the general-purpose event/period counter in datapath and timer blocks; a single instance serves one channel.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- MAX_VAL, 9, highest legal count; range is 0..MAX_VAL (modulus MAX_VAL+1). Must be <= 2^WIDTH-1.
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.
- RESET_VAL, 0, count value after reset. Must be <= MAX_VAL.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per enabled cycle.
- dir  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- data  input  WIDTH  load value.
- clr_ovf  input  1  clears ovf_sticky.
- count  output  WIDTH  current count (registered).
- at_max  output  1  combinational: count == MAX_VAL.
- at_min  output  1  combinational: count == 0.
- bnd_pulse  output  1  registered one-cycle pulse on a boundary event.
- ovf_sticky  output  1  registered sticky flag, set on any boundary event.

Behaviour:
- Reset is synchronous and active-high on clk: count=RESET_VAL, bnd_pulse=0, ovf_sticky=0. Reset overrides all other inputs.
- Priority per edge: rst > load > en. With en=0 and load=0, count holds.
- Load: count <= data, or MAX_VAL if data > MAX_VAL (clamp). A load never produces a boundary event; bnd_pulse=0 that cycle.
- Up step (en=1, dir=1):
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: boundary event. SATURATE=0 gives count <= 0; SATURATE=1 holds MAX_VAL.
- Down step (en=1, dir=0):
  - count > 0: count-1.
  - count == 0: boundary event. SATURATE=0 gives count <= MAX_VAL; SATURATE=1 holds 0.
- Boundary event: bnd_pulse is 1 for exactly the cycle after the event edge, i.e. registered alongside the new count. Consecutive events, such as repeated up steps while saturated, keep bnd_pulse high each cycle.
- Boundary event arithmetic: comparisons are against MAX_VAL, not 2^WIDTH-1. No intermediate WIDTH+1 overflow may leak into count.
- Latency: one clk from the en/load edge to the count update. at_max and at_min follow count combinationally, with no extra delay.
- ovf_sticky:
  - Set on the edge of any boundary event.
  - Cleared by clr_ovf=1.
  - Set wins if an event and clr_ovf occur on the same edge.
  - Unaffected by load.
- Direction may change on any cycle; each step uses the dir value sampled at that edge.
- Reset mid-count: the next edge applies reset values regardless of en/load/dir. The event from that edge is discarded.
- Degenerate MAX_VAL=2^WIDTH-1 must behave identically to a plain binary counter with flags.

Test Plan:
- rst=1 for 2 cycles with en=1, load=1, data=7 -> count=0, bnd_pulse=0, ovf_sticky=0, at_min=1.
- load=1 data=4 for 1 cycle, then en=1 dir=1 for 6 cycles (SATURATE=0, MAX_VAL=9) -> count 4,5,6,7,8,9,0. bnd_pulse=1 only in the cycle count=0. ovf_sticky=1. at_max=1 while count=9.
- Load data=1, then en=1 dir=0 for 3 cycles -> count 1,0,9. bnd_pulse on the 9. Next, clr_ovf=1 alone for one cycle -> ovf_sticky=0.
- SATURATE=1 instance: load 8, en=1 dir=1 for 4 cycles -> count 8,9,9,9, bnd_pulse high for the last two. Then dir=0 from 0 -> count holds 0, bnd_pulse=1.
- Load data=15 (> MAX_VAL) -> count=9. Load with en=1 in the same cycle -> load value taken, no step. clr_ovf coinciding with a wrap event -> ovf_sticky stays 1.
- Mid-count rst asserted while count=9 with en=1 dir=1 (RESET_VAL=3 instance) -> count=3, bnd_pulse=0, ovf_sticky=0 on the next cycle.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with a configurable modulus and a choice of wrap or saturate.
// It provides boundary flags, a one-cycle boundary-event pulse and a sticky overflow flag.
module mod_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 9,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             bnd_pulse,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             bnd_evt;

    // Limits are checked before stepping, so count+1 and count-1 stay within 0..MAX_VAL.
    always_comb begin
        count_nxt = count;
        bnd_evt   = 1'b0;
        if (load) begin
            count_nxt = (data > MAX_C) ? MAX_C : data;
        end else if (en) begin
            if (dir) begin
                if (count == MAX_C) begin
                    bnd_evt   = 1'b1;
                    count_nxt = SATURATE ? MAX_C : '0;
                end else begin
                    count_nxt = count + ONE_C;
                end
            end else begin
                if (count == '0) begin
                    bnd_evt   = 1'b1;
                    count_nxt = SATURATE ? '0 : MAX_C;
                end else begin
                    count_nxt = count - ONE_C;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= RESET_C;
            bnd_pulse  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count      <= count_nxt;
            bnd_pulse  <= bnd_evt;
            ovf_sticky <= bnd_evt | (ovf_sticky & ~clr_ovf);
        end
    end

    assign at_max = (count == MAX_C);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: three instances (wrap, saturate, RESET_VAL=3) share one stimulus.
// Expected results are queued as each step is driven and are compared after the clock edge.
module tb_mod_updown_counter;

    typedef struct {
        string      tag;
        int         inst;
        logic [3:0] cnt;
        logic       bnd;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, dir, load, clr_ovf;
    logic [3:0] data;
    logic [3:0] cnt  [3];
    logic       amax [3];
    logic       amin [3];
    logic       bnd  [3];
    logic       ovf  [3];

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .data(data), .clr_ovf(clr_ovf),
        .count(cnt[0]), .at_max(amax[0]), .at_min(amin[0]), .bnd_pulse(bnd[0]), .ovf_sticky(ovf[0])
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .data(data), .clr_ovf(clr_ovf),
        .count(cnt[1]), .at_max(amax[1]), .at_min(amin[1]), .bnd_pulse(bnd[1]), .ovf_sticky(ovf[1])
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(3)) u_rv3 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .data(data), .clr_ovf(clr_ovf),
        .count(cnt[2]), .at_max(amax[2]), .at_min(amin[2]), .bnd_pulse(bnd[2]), .ovf_sticky(ovf[2])
    );

    task automatic expect_val(input string tag, input int inst, input logic [3:0] c,
                              input logic b, input logic o);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.cnt  = c;
        e.bnd  = b;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic check_one(input exp_t e);
        logic exp_max, exp_min;
        exp_max = (e.cnt == 4'd9);
        exp_min = (e.cnt == 4'd0);
        checks++;
        assert (cnt[e.inst] === e.cnt) else begin
            errors++;
            $error("FAIL %s.count inst%0d got %0d expected %0d", e.tag, e.inst, cnt[e.inst], e.cnt);
        end
        checks++;
        assert (bnd[e.inst] === e.bnd) else begin
            errors++;
            $error("FAIL %s.bnd_pulse inst%0d got %b expected %b", e.tag, e.inst, bnd[e.inst], e.bnd);
        end
        checks++;
        assert (ovf[e.inst] === e.ovf) else begin
            errors++;
            $error("FAIL %s.ovf_sticky inst%0d got %b expected %b", e.tag, e.inst, ovf[e.inst], e.ovf);
        end
        checks++;
        assert (amax[e.inst] === exp_max) else begin
            errors++;
            $error("FAIL %s.at_max inst%0d got %b expected %b", e.tag, e.inst, amax[e.inst], exp_max);
        end
        checks++;
        assert (amin[e.inst] === exp_min) else begin
            errors++;
            $error("FAIL %s.at_min inst%0d got %b expected %b", e.tag, e.inst, amin[e.inst], exp_min);
        end
    endtask

    // Drive one cycle of inputs before the rising edge, then check every queued expectation just after it.
    task automatic step(input logic r, input logic e, input logic d, input logic l,
                        input logic [3:0] dt, input logic c);
        @(negedge clk);
        rst     = r;
        en      = e;
        dir     = d;
        load    = l;
        data    = dt;
        clr_ovf = c;
        @(posedge clk);
        #1;
        while (sb.size() > 0) check_one(sb.pop_front());
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; data = '0; clr_ovf = 1'b0;

        // Reset overrides a simultaneous load and enable.
        expect_val("rst0", 0, 4'd0, 1'b0, 1'b0);
        step(1, 1, 1, 1, 4'd7, 0);
        expect_val("rst1", 0, 4'd0, 1'b0, 1'b0);
        expect_val("rst1", 2, 4'd3, 1'b0, 1'b0);
        step(1, 1, 1, 1, 4'd7, 0);

        // Wrap instance: load 4, count up through 9 and wrap to 0.
        expect_val("ld4", 0, 4'd4, 1'b0, 1'b0);
        step(0, 0, 0, 1, 4'd4, 0);
        expect_val("up5", 0, 4'd5, 1'b0, 1'b0); step(0, 1, 1, 0, 4'd0, 0);
        expect_val("up6", 0, 4'd6, 1'b0, 1'b0); step(0, 1, 1, 0, 4'd0, 0);
        expect_val("up7", 0, 4'd7, 1'b0, 1'b0); step(0, 1, 1, 0, 4'd0, 0);
        expect_val("up8", 0, 4'd8, 1'b0, 1'b0); step(0, 1, 1, 0, 4'd0, 0);
        expect_val("up9", 0, 4'd9, 1'b0, 1'b0);
        expect_val("sat_up9", 1, 4'd9, 1'b0, 1'b0);
        step(0, 1, 1, 0, 4'd0, 0);
        expect_val("wrap0", 0, 4'd0, 1'b1, 1'b1);
        expect_val("sat_hold9", 1, 4'd9, 1'b1, 1'b1);
        step(0, 1, 1, 0, 4'd0, 0);
        expect_val("idle", 0, 4'd0, 1'b0, 1'b1);
        step(0, 0, 1, 0, 4'd0, 0);

        // Down through 0 wraps to MAX_VAL; load leaves ovf_sticky alone.
        expect_val("ld1", 0, 4'd1, 1'b0, 1'b1);
        step(0, 0, 0, 1, 4'd1, 0);
        expect_val("dn0", 0, 4'd0, 1'b0, 1'b1);
        step(0, 1, 0, 0, 4'd0, 0);
        expect_val("dnwrap9", 0, 4'd9, 1'b1, 1'b1);
        expect_val("sat_dnhold0", 1, 4'd0, 1'b1, 1'b1);
        step(0, 1, 0, 0, 4'd0, 0);
        expect_val("clr", 0, 4'd9, 1'b0, 1'b0);
        expect_val("sat_clr", 1, 4'd0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 4'd0, 1);

        // Saturating instance: 8, 9, 9, 9 with a pulse on each held step.
        expect_val("sat_ld8", 1, 4'd8, 1'b0, 1'b0); step(0, 0, 0, 1, 4'd8, 0);
        expect_val("sat_up9b", 1, 4'd9, 1'b0, 1'b0); step(0, 1, 1, 0, 4'd0, 0);
        expect_val("sat_hold1", 1, 4'd9, 1'b1, 1'b1);
        expect_val("wrap_from9", 0, 4'd0, 1'b1, 1'b1);
        step(0, 1, 1, 0, 4'd0, 0);
        expect_val("sat_hold2", 1, 4'd9, 1'b1, 1'b1); step(0, 1, 1, 0, 4'd0, 0);
        expect_val("sat_ld0", 1, 4'd0, 1'b0, 1'b1); step(0, 0, 0, 1, 4'd0, 0);
        expect_val("sat_dn_at0", 1, 4'd0, 1'b1, 1'b1); step(0, 1, 0, 0, 4'd0, 0);

        // Clamped load, load beating enable, and set beating clear.
        expect_val("ld15clamp", 0, 4'd9, 1'b0, 1'b1);
        expect_val("sat_ld15clamp", 1, 4'd9, 1'b0, 1'b1);
        step(0, 0, 0, 1, 4'd15, 0);
        expect_val("ld_over_en", 0, 4'd2, 1'b0, 1'b1); step(0, 1, 1, 1, 4'd2, 0);
        expect_val("ld_over_en_dn", 0, 4'd5, 1'b0, 1'b1); step(0, 1, 0, 1, 4'd5, 0);
        expect_val("clr2", 0, 4'd5, 1'b0, 1'b0); step(0, 0, 0, 0, 4'd0, 1);
        expect_val("ld9", 0, 4'd9, 1'b0, 1'b0); step(0, 0, 0, 1, 4'd9, 0);
        expect_val("set_wins", 0, 4'd0, 1'b1, 1'b1); step(0, 1, 1, 0, 4'd0, 1);
        expect_val("dir_flip", 0, 4'd9, 1'b1, 1'b1); step(0, 1, 0, 0, 4'd0, 0);
        expect_val("hold_en0", 0, 4'd9, 1'b0, 1'b1); step(0, 0, 0, 0, 4'd0, 0);

        // RESET_VAL=3 instance: reset at MAX_VAL with an up step pending discards the event.
        expect_val("rv3_ld9", 2, 4'd9, 1'b0, 1'b1); step(0, 0, 0, 1, 4'd9, 0);
        expect_val("rv3_midrst", 2, 4'd3, 1'b0, 1'b0);
        expect_val("midrst", 0, 4'd0, 1'b0, 1'b0);
        step(1, 1, 1, 0, 4'd0, 0);
        expect_val("rv3_up4", 2, 4'd4, 1'b0, 1'b0); step(0, 1, 1, 0, 4'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
